// File: rtl/sr_pq.sv
// Shift-register priority queue: DEPTH cells kept sorted by unsigned key, head at cell 0.
// Push, pop and push+pop each complete in one cycle; equal keys leave in arrival order.
module sr_pq #(
  parameter int KW    = 4,
  parameter int VW    = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [KW+VW-1:0] kvi,
  output logic [KW+VW-1:0] kvo,
  output logic             full,
  output logic             empty
);

  localparam int EW = KW + VW;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [EW-1:0]    ent_q [DEPTH];
  logic [EW-1:0]    ent_d [DEPTH];

  // State after the optional pop, before the optional insert.
  logic [DEPTH-1:0] sh_v;
  logic [EW-1:0]    sh_e [DEPTH];
  logic [DEPTH-1:0] gt;
  logic             do_pop, do_push;

  assign empty = ~valid_q[0];
  assign full  = valid_q[DEPTH-1];
  assign kvo   = valid_q[0] ? ent_q[0] : '0;

  always_comb begin
    do_pop  = pop & valid_q[0];
    // A simultaneous pop frees a slot, so push+pop is accepted even when full.
    do_push = push & (~valid_q[DEPTH-1] | do_pop);

    for (int i = 0; i < DEPTH - 1; i++) begin
      sh_v[i] = do_pop ? valid_q[i+1] : valid_q[i];
      sh_e[i] = do_pop ? ent_q[i+1]   : ent_q[i];
    end
    sh_v[DEPTH-1] = do_pop ? 1'b0 : valid_q[DEPTH-1];
    sh_e[DEPTH-1] = do_pop ? '0   : ent_q[DEPTH-1];

    // Strictly-greater keeps equal keys in FIFO order; the mask is monotonic
    // because valid cells are contiguous and sorted.
    for (int i = 0; i < DEPTH; i++) begin
      gt[i] = ~sh_v[i] | (sh_e[i][EW-1:VW] > kvi[EW-1:VW]);
    end

    valid_d = sh_v;
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = sh_e[i];
    end

    if (do_push) begin
      if (gt[0]) begin
        valid_d[0] = 1'b1;
        ent_d[0]   = kvi;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (gt[i]) begin
          valid_d[i] = gt[i-1] ? sh_v[i-1] : 1'b1;
          ent_d[i]   = gt[i-1] ? sh_e[i-1] : kvi;
        end
      end
    end
  end

  // NOTE: every storage cell is reset, not just the valid bits, so an empty
  // queue always presents zeroed entries and nothing stale can resurface.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every cell samples the pre-edge neighbours.
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sr_pq.sv
// Self-checking bench for sr_pq: directed scenarios plus random push/pop traffic
// compared against a sequence-numbered reference queue.
module tb_sr_pq;

  localparam int KW    = 4;
  localparam int VW    = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [7:0] kvi;
  logic [7:0] kvo;
  logic       full;
  logic       empty;

  int total;
  int bad;

  typedef struct {
    logic [7:0] kv;
    int         seq;
  } ent_t;

  ent_t model_q[$];
  int   seq_n;

  sr_pq #(.KW(KW), .VW(VW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .kvi  (kvi),
    .kvo  (kvo),
    .full (full),
    .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Head = smallest key; among equal keys, the earliest arrival.
  function automatic int head_idx();
    int best;
    best = 0;
    for (int i = 1; i < model_q.size(); i++) begin
      if (model_q[i].kv[7:4] < model_q[best].kv[7:4] ||
          (model_q[i].kv[7:4] == model_q[best].kv[7:4] && model_q[i].seq < model_q[best].seq))
        best = i;
    end
    return best;
  endfunction

  task automatic model_step(input logic p, input logic po, input logic [7:0] k);
    ent_t e;
    if (po && model_q.size() > 0) model_q.delete(head_idx());
    if (p && model_q.size() < DEPTH) begin
      e.kv  = k;
      e.seq = seq_n++;
      model_q.push_back(e);
    end
  endtask

  function automatic logic [7:0] model_kvo();
    if (model_q.size() == 0) return 8'h00;
    return model_q[head_idx()].kv;
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".kvo"},   32'(kvo),   32'(model_kvo()));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  // Drive one cycle of stimulus, advance the model, check just after the edge.
  task automatic step(input logic p, input logic po, input logic [7:0] k, input string tag);
    push = p;
    pop  = po;
    kvi  = k;
    @(posedge clk);
    model_step(p, po, k);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    kvi  = 8'h00;
    compare_model(tag);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    seq_n = 0;
    rst   = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    kvi   = 8'h00;
    #12;
    check("rst.kvo",   32'(kvo),   32'h00);
    check("rst.empty", 32'(empty), 32'h1);
    check("rst.full",  32'(full),  32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic ordering and push+pop replacement.
    step(1, 0, 8'h44, "p44");
    step(1, 0, 8'h55, "p55");
    check("d029.kvo", 32'(kvo), 32'h44);
    check("d029.empty", 32'(empty), 32'h0);
    step(1, 0, 8'h66, "p66");
    step(1, 0, 8'h33, "p33");
    check("d030.kvo", 32'(kvo), 32'h33);
    check("d030.full", 32'(full), 32'h1);
    step(0, 1, 8'h00, "pop1");
    check("d031.kvo", 32'(kvo), 32'h44);
    check("d031.full", 32'(full), 32'h0);
    step(1, 1, 8'h77, "pp77");
    check("d031b.kvo", 32'(kvo), 32'h55);
    step(0, 1, 8'h00, "drain55");
    check("d031.ord66", 32'(kvo), 32'h66);
    step(0, 1, 8'h00, "drain66");
    check("d031.ord77", 32'(kvo), 32'h77);
    step(0, 1, 8'h00, "drain77");
    check("d031.empty", 32'(empty), 32'h1);

    // Full queue: plain push ignored, push+pop accepted.
    step(1, 0, 8'h3C, "f3");
    step(1, 0, 8'h1A, "f1");
    step(1, 0, 8'h4D, "f4");
    step(1, 0, 8'h2B, "f2");
    step(1, 0, 8'h05, "push_full");
    check("d032.kvo", 32'(kvo), 32'h1A);
    check("d032.full", 32'(full), 32'h1);
    step(1, 1, 8'h05, "pp_full");
    check("d032b.kvo", 32'(kvo), 32'h05);
    check("d032b.full", 32'(full), 32'h1);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'h00, "drain_f");

    // Equal keys stay FIFO; pop on empty ignored.
    step(1, 0, 8'h21, "eq21");
    step(1, 0, 8'h22, "eq22");
    check("d033.a", 32'(kvo), 32'h21);
    step(0, 1, 8'h00, "eqpop1");
    check("d033.b", 32'(kvo), 32'h22);
    step(0, 1, 8'h00, "eqpop2");
    check("d033.c", 32'(kvo), 32'h00);
    check("d033.empty", 32'(empty), 32'h1);
    step(0, 1, 8'h00, "pop_empty");
    check("d033.empty2", 32'(empty), 32'h1);
    step(1, 1, 8'h9E, "pp_empty");
    check("pp_empty.kvo", 32'(kvo), 32'h9E);

    // Asynchronous reset mid-cycle with entries stored.
    step(1, 0, 8'h31, "r1");
    step(1, 0, 8'h12, "r2");
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    check("d034.kvo",   32'(kvo),   32'h00);
    check("d034.empty", 32'(empty), 32'h1);
    check("d034.full",  32'(full),  32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1, 0, 8'hA7, "post_rst");

    // Random traffic biased toward pushes so full and empty both get exercised.
    for (int n = 0; n < 500; n++) begin
      logic       p, po;
      logic [7:0] k;
      p  = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      k  = 8'($urandom_range(0, 255));
      step(p, po, k, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
